demux1x32_frame: RTL and testbench
==================================

# demux1x32_frame

Registered 1-to-32 demultiplexer and frame assembler, the inverse of the team's 32:1 bit-select mux. It routes one serial input bit per accepted beat into one of 32 output lanes, chosen either by an explicit 5-bit select or by an internal auto-incrementing pointer. Once all 32 lanes have been written, it captures a complete 32-bit word and presents it downstream over a valid/ready handshake.

## Interface
Parameters:
- RESET_VAL, 32'h0000_0000, reset value of the `lanes` register

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_bit  input  1  serial data bit to route
- sel  input  5  target lane when auto_inc=0
- in_valid  input  1  beat offered
- in_ready  output  1  beat can be accepted; combinational
- auto_inc  input  1  1: ignore sel and use the internal pointer; 0: use sel
- clear  input  1  synchronous abort of the current frame
- lanes  output  32  live demux outputs; each bit holds the last value written to it
- lane_mask  output  32  lanes written in the current frame
- word  output  32  captured complete frame
- word_valid  output  1  word available
- word_ready  input  1  downstream accepts word
- dup_err  output  1  one-cycle pulse on a re-write of an already-written lane within a frame

## Operation
- in_ready = ~clear & (~word_valid | word_ready).
- A beat is accepted when accept = in_valid & in_ready.
- Target index: idx = auto_inc ? ptr : sel. ptr is a 5-bit internal register.
- On accept:
  - lanes[idx] <= in_bit.
  - lane_mask[idx] <= 1.
  - If auto_inc=1, ptr <= ptr+1, wrapping 31->0. If auto_inc=0, ptr is unchanged.
- Duplicate write: if lane_mask[idx] is already 1 at accept, dup_err <= 1 for one cycle. The write still happens and lane_mask is unchanged.
- Frame complete: an accept where (lane_mask | onehot(idx)) == 32'hFFFF_FFFF. On that accept:
  - word <= lanes with bit idx replaced by in_bit.
  - word_valid <= 1.
  - lane_mask <= 0.
  - ptr <= 0.
- Handshake:
  - If word_valid & word_ready and no frame completes this cycle, word_valid <= 0.
  - If a frame completes in the same cycle, word_valid stays 1 and word takes the new value.
- Clear (synchronous, highest priority):
  - lane_mask <= 0, ptr <= 0, dup_err <= 0.
  - No beat is accepted in that cycle.
  - lanes, word and word_valid are untouched. A pending word still handshakes normally.
- Switching auto_inc mid-frame is legal. lane_mask keeps tracking which lanes were written regardless of mode.
- Reset (rst_n low, asynchronous):
  - lanes=RESET_VAL, lane_mask=0, ptr=0, word=0, word_valid=0, dup_err=0.
  - Hence in_ready=1 whenever clear=0.
  - Reset asserted mid-frame or with a word pending discards everything.

## Timing
- All outputs except in_ready are registered and update on the clk edge that performs the accept.
- Latency: word_valid rises on the edge of the 32nd distinct-lane accept and is visible in the following cycle.
- Throughput: one bit per cycle. With word_ready held at 1, back-to-back frames have zero bubbles.
- Backpressure: while word_valid=1 and word_ready=0, in_ready=0 and lanes, lane_mask and ptr hold their values.
- in_ready follows word_ready combinationally in the same cycle. There is no combinational path from in_valid to in_ready.
- dup_err is high for exactly the one cycle after the offending accept.

## Test plan
- Reset mid-frame: pull rst_n low after 10 accepts -> lanes=RESET_VAL, lane_mask=0, word_valid=0, in_ready=1 immediately (asynchronous), and the next frame requires 32 accepts.
- Auto-increment frame: auto_inc=1, word_ready=1, 32 consecutive beats carrying 32'hA5A5_0F0F LSB first -> word=32'hA5A5_0F0F and lanes=32'hA5A5_0F0F; word_valid is high for exactly one cycle, the cycle after the 32nd beat; lane_mask=0 and ptr=0 afterwards.
- Addressed frame with duplicate: auto_inc=0, sel 31 down to 0 carrying bits of 32'h1234_5678, with an extra write to sel=3 partway through -> dup_err pulses once, the frame still completes after all 32 distinct lanes, and word reflects the last bit written to lane 3.
- Backpressure: complete a frame with word_ready=0 and keep in_valid=1 -> in_ready=0 and lanes, lane_mask and ptr frozen for 5 cycles; raise word_ready -> in_ready=1 in the same cycle, word_valid drops on the next edge, and the beat is accepted.
- Clear mid-frame: clear=1 for one cycle after 10 accepts with in_valid=1 -> no accept that cycle, lane_mask=0 and ptr=0; lanes keep the 10 written bits; the next frame needs a full 32 accepts.
- Back-to-back frames: 64 continuous beats with word_ready=1 -> word_valid high the cycle after beat 32 and the cycle after beat 64, low in between; in_ready stays 1 throughout.

Source files
------------

// File: rtl/demux1x32_frame.sv
// rtl/demux1x32_frame.sv - registered 1:32 bit demultiplexer with frame assembly
// Routes one serial bit per beat to a lane and hands off a full 32-bit word.
module demux1x32_frame #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_bit,
   input  logic [4:0]  sel,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        auto_inc,
   input  logic        clear,
   output logic [31:0] lanes,
   output logic [31:0] lane_mask,
   output logic [31:0] word,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        dup_err
);

   logic [31:0] r_lanes;
   logic [31:0] r_mask;
   logic [4:0]  r_ptr;
   logic [31:0] r_word;
   logic        r_word_valid;
   logic        r_dup_err;

   logic        w_accept;
   logic [4:0]  w_idx;
   logic [31:0] w_onehot;
   logic [31:0] w_lanes_next;
   logic        w_dup;
   logic        w_complete;
   logic        w_drain;

   assign in_ready     = ~clear & (~r_word_valid | word_ready);
   assign w_accept     = in_valid & in_ready;
   assign w_idx        = auto_inc ? r_ptr : sel;
   assign w_onehot     = 32'd1 << w_idx;
   assign w_lanes_next = (r_lanes & ~w_onehot) | (in_bit ? w_onehot : 32'd0);
   assign w_dup        = |(r_mask & w_onehot);
   assign w_complete   = w_accept & ((r_mask | w_onehot) == 32'hFFFF_FFFF);
   assign w_drain      = r_word_valid & word_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lanes      <= RESET_VAL;
         r_mask       <= 32'd0;
         r_ptr        <= 5'd0;
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
         r_dup_err    <= 1'b0;
      end else if (clear) begin
         // Abort the frame only; a pending word still drains.
         r_mask    <= 32'd0;
         r_ptr     <= 5'd0;
         r_dup_err <= 1'b0;
         if (w_drain) begin
            r_word_valid <= 1'b0;
         end
      end else begin
         r_dup_err <= w_accept & w_dup;
         if (w_accept) begin
            r_lanes <= w_lanes_next;
            if (w_complete) begin
               r_word       <= w_lanes_next;
               r_word_valid <= 1'b1;
               r_mask       <= 32'd0;
               r_ptr        <= 5'd0;
            end else begin
               r_mask <= r_mask | w_onehot;
               if (auto_inc) begin
                  r_ptr <= r_ptr + 5'd1;
               end
            end
         end
         if (w_drain && !w_complete) begin
            r_word_valid <= 1'b0;
         end
      end
   end

   assign lanes      = r_lanes;
   assign lane_mask  = r_mask;
   assign word       = r_word;
   assign word_valid = r_word_valid;
   assign dup_err    = r_dup_err;

endmodule

// File: tb/tb_demux1x32_frame.sv
// tb/tb_demux1x32_frame.sv - randomized bench for demux1x32_frame
// Reference model keeps lanes and written flags as plain arrays.
module tb_demux1x32_frame;

   localparam logic [31:0] RV = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_bit;
   logic [4:0]  sel;
   logic        in_valid;
   logic        in_ready;
   logic        auto_inc;
   logic        clear;
   logic [31:0] lanes;
   logic [31:0] lane_mask;
   logic [31:0] word;
   logic        word_valid;
   logic        word_ready;
   logic        dup_err;

   int n_tests = 0;
   int n_fail  = 0;

   bit        m_lane[32];
   bit        m_written[32];
   int        m_ptr;
   bit [31:0] m_word;
   bit        m_wv;
   bit        m_dup;

   demux1x32_frame #(.RESET_VAL(RV)) dut (
      .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .auto_inc(auto_inc), .clear(clear), .lanes(lanes),
      .lane_mask(lane_mask), .word(word), .word_valid(word_valid),
      .word_ready(word_ready), .dup_err(dup_err)
   );

   always #5 clk = ~clk;

   function automatic bit [31:0] pack_lanes();
      bit [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_lane[i];
      return v;
   endfunction

   function automatic bit [31:0] pack_written();
      bit [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_written[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_lane[i]    = RV[i];
         m_written[i] = 1'b0;
      end
      m_ptr  = 0;
      m_word = '0;
      m_wv   = 1'b0;
      m_dup  = 1'b0;
   endtask

   // Drive one cycle starting just after a rising edge, scoreboard against the model.
   task automatic step(input bit v, input bit b, input bit [4:0] s, input bit a,
                       input bit c, input bit wr);
      bit exp_ready, acc, complete;
      int idx, cnt;
      in_valid = v; in_bit = b; sel = s; auto_inc = a; clear = c; word_ready = wr;
      exp_ready = !c && (!m_wv || wr);
      #1;
      n_tests++;
      if (in_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
      end
      @(posedge clk);
      acc = v && exp_ready;
      complete = 1'b0;
      if (c) begin
         for (int i = 0; i < 32; i++) m_written[i] = 1'b0;
         m_ptr = 0;
         m_dup = 1'b0;
         if (m_wv && wr) m_wv = 1'b0;
      end else begin
         m_dup = 1'b0;
         if (acc) begin
            idx = a ? m_ptr : int'(s);
            m_dup = m_written[idx];
            m_lane[idx] = b;
            m_written[idx] = 1'b1;
            cnt = 0;
            for (int i = 0; i < 32; i++) cnt += m_written[i];
            if (cnt == 32) begin
               complete = 1'b1;
               m_word = pack_lanes();
               for (int i = 0; i < 32; i++) m_written[i] = 1'b0;
               m_ptr = 0;
            end else if (a) begin
               m_ptr = (m_ptr + 1) % 32;
            end
         end
         if (complete) m_wv = 1'b1;
         else if (m_wv && wr) m_wv = 1'b0;
      end
      #1;
      n_tests++;
      if (lanes !== pack_lanes() || lane_mask !== pack_written() || word !== m_word ||
          word_valid !== m_wv || dup_err !== m_dup) begin
         n_fail++;
         $display("FAIL state: got lanes=%h mask=%h word=%h wv=%b dup=%b expected lanes=%h mask=%h word=%h wv=%b dup=%b",
                  lanes, lane_mask, word, word_valid, dup_err,
                  pack_lanes(), pack_written(), m_word, m_wv, m_dup);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if (lanes !== RV || lane_mask !== 32'd0 || word !== 32'd0 || word_valid !== 1'b0 ||
          dup_err !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: lanes=%h mask=%h word=%h wv=%b dup=%b rdy=%b expected lanes=%h zeros rdy=1",
                  lanes, lane_mask, word, word_valid, dup_err, in_ready, RV);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 10; i++) step(1, 1'($urandom), 5'd0, 1, 0, 1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      model_reset();
      n_tests++;
      if (lanes !== RV || lane_mask !== 32'd0 || word_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_async: lanes=%h mask=%h wv=%b rdy=%b expected lanes=%h mask=0 wv=0 rdy=1",
                  lanes, lane_mask, word_valid, in_ready, RV);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 31; i++) step(1, 1'($urandom), 5'd0, 1, 0, 1);
      n_tests++;
      if (word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_refill_early: wv=%b expected 0 after 31 beats", word_valid);
      end
      step(1, 1'($urandom), 5'd0, 1, 0, 1);
      n_tests++;
      if (word_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_refill_done: wv=%b expected 1 after 32 beats", word_valid);
      end
   endtask

   task automatic test_auto_frame();
      bit [31:0] pat = 32'hA5A5_0F0F;
      for (int i = 0; i < 32; i++) step(1, pat[i], 5'($urandom), 1, 0, 1);
      n_tests++;
      if (word !== pat || lanes !== pat || word_valid !== 1'b1 || lane_mask !== 32'd0) begin
         n_fail++;
         $display("FAIL auto_frame: word=%h lanes=%h wv=%b mask=%h expected word=lanes=%h wv=1 mask=0",
                  word, lanes, word_valid, lane_mask, pat);
      end
      step(0, 0, 5'd0, 1, 0, 1);
      n_tests++;
      if (word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL auto_one_cycle: wv=%b expected 0", word_valid);
      end
      step(1, 1, 5'd9, 1, 0, 1);
      n_tests++;
      if (lane_mask !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL auto_ptr_zero: mask=%h expected 00000001", lane_mask);
      end
   endtask

   task automatic test_addressed_dup();
      bit [31:0] pat = 32'h1234_5678;
      int dups = 0;
      step(0, 0, 5'd0, 0, 1, 1);
      for (int s = 31; s >= 0; s--) begin
         step(1, pat[s], 5'(s), 0, 0, 1);
         if (dup_err === 1'b1) dups++;
         if (s == 3) begin
            step(1, ~pat[3], 5'd3, 0, 0, 1);
            if (dup_err === 1'b1) dups++;
         end
      end
      n_tests++;
      if (dups != 1) begin
         n_fail++;
         $display("FAIL addr_dup_count: got %0d pulses expected 1", dups);
      end
      n_tests++;
      if (word_valid !== 1'b1 || word !== 32'h1234_5670) begin
         n_fail++;
         $display("FAIL addr_word: wv=%b word=%h expected wv=1 word=12345670", word_valid, word);
      end
   endtask

   task automatic test_backpressure();
      bit [31:0] snap_l, snap_m;
      step(0, 0, 5'd0, 1, 1, 1);
      for (int i = 0; i < 32; i++) step(1, 1'($urandom), 5'd0, 1, 0, 0);
      snap_l = lanes;
      snap_m = lane_mask;
      for (int i = 0; i < 5; i++) begin
         step(1, 1'($urandom), 5'd0, 1, 0, 0);
         n_tests++;
         if (in_ready !== 1'b0 || lanes !== snap_l || lane_mask !== snap_m || word_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: rdy=%b lanes=%h mask=%h wv=%b expected rdy=0 lanes=%h mask=%h wv=1",
                     in_ready, lanes, lane_mask, word_valid, snap_l, snap_m);
         end
      end
      in_valid = 1'b1; word_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_comb: rdy=%b expected 1", in_ready);
      end
      step(1, 1, 5'd0, 1, 0, 1);
      n_tests++;
      if (word_valid !== 1'b0 || lane_mask !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL bp_release: wv=%b mask=%h expected wv=0 mask=00000001", word_valid, lane_mask);
      end
   endtask

   task automatic test_clear_mid();
      bit [31:0] snap_l;
      step(0, 0, 5'd0, 1, 1, 1);
      for (int i = 0; i < 10; i++) step(1, 1'($urandom), 5'd0, 1, 0, 1);
      snap_l = lanes;
      step(1, 1'($urandom), 5'd0, 1, 1, 1);
      n_tests++;
      if (lane_mask !== 32'd0 || lanes !== snap_l) begin
         n_fail++;
         $display("FAIL clear_mid: mask=%h lanes=%h expected mask=0 lanes=%h", lane_mask, lanes, snap_l);
      end
      for (int i = 0; i < 31; i++) step(1, 1'($urandom), 5'd0, 1, 0, 1);
      n_tests++;
      if (word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_refill_early: wv=%b expected 0", word_valid);
      end
      step(1, 1'($urandom), 5'd0, 1, 0, 1);
      n_tests++;
      if (word_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_refill_done: wv=%b expected 1", word_valid);
      end
   endtask

   task automatic test_back_to_back();
      step(0, 0, 5'd0, 1, 1, 1);
      for (int k = 1; k <= 64; k++) begin
         step(1, 1'($urandom), 5'd0, 1, 0, 1);
         n_tests++;
         if (word_valid !== ((k == 32) || (k == 64))) begin
            n_fail++;
            $display("FAIL b2b_wv: beat %0d wv=%b expected %b", k, word_valid, (k == 32) || (k == 64));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
              1'($urandom_range(0, 2) != 0));
      end
   endtask

   initial begin
      rst_n = 1'b0; in_bit = 1'b0; sel = 5'd0; in_valid = 1'b0;
      auto_inc = 1'b0; clear = 1'b0; word_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      test_reset_mid_frame();
      test_auto_frame();
      test_addressed_dup();
      test_backpressure();
      test_clear_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
